// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA timing generator with character-cell
// coordinates and text-pipeline strobes. Every output is a register loaded
// from the next counter state, so outputs always describe the current xpos/ypos.
module vga_timing_param #(
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned H_FRONT    = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BACK     = 64,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned V_FRONT    = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BACK     = 23,
  parameter int unsigned HSYNC_POL  = 0,
  parameter int unsigned VSYNC_POL  = 0,
  parameter int unsigned CHAR_W     = 8,
  parameter int unsigned CHAR_H     = 10,
  parameter int unsigned LOAD_LEAD  = 7,
  parameter int unsigned DESIGN_LAG = 2,
  parameter int unsigned COLS_W     = 7,
  parameter int unsigned ROWS_W     = 6,
  parameter int unsigned FCNT_W     = 6
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          pix_en,
  output logic                                          hsync,
  output logic                                          vsync,
  output logic [COORD_W-1:0]                            xpos,
  output logic [COORD_W-1:0]                            ypos,
  output logic                                          drawing,
  output logic [$clog2(CHAR_W)-1:0]                     xchar,
  output logic [((CHAR_H > 1) ? $clog2(CHAR_H) : 1)-1:0] ychar,
  output logic [COLS_W-1:0]                             xtext,
  output logic [ROWS_W-1:0]                             ytext,
  output logic                                          load_char,
  output logic                                          load_design,
  output logic                                          draw_char,
  output logic                                          line_start,
  output logic                                          frame_start,
  output logic [FCNT_W-1:0]                             frame_count
);

  localparam int unsigned HT        = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned VT        = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int unsigned XC_W      = $clog2(CHAR_W);
  localparam int unsigned YC_W      = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int unsigned H_SYNC_ST = HT - H_SYNC;
  localparam int unsigned V_SYNC_ST = VT - V_SYNC;
  localparam int unsigned H_VIS_END = H_BACK + H_VISIBLE;
  localparam int unsigned V_VIS_END = V_BACK + V_VISIBLE;
  localparam int unsigned LW_START  = H_BACK - LOAD_LEAD;
  localparam int unsigned LW_END    = H_BACK + H_VISIBLE - LOAD_LEAD;
  localparam int unsigned LD_START  = LW_START + DESIGN_LAG;
  localparam int unsigned LD_END    = LW_END + DESIGN_LAG;
  localparam int unsigned DC_START  = H_BACK - 1;
  localparam logic        HS_ACT    = 1'(HSYNC_POL);
  localparam logic        VS_ACT    = 1'(VSYNC_POL);

  logic               w_x_wrap;
  logic               w_y_wrap;
  logic [COORD_W-1:0] w_nx;
  logic [COORD_W-1:0] w_ny;
  logic               w_hdraw;
  logic               w_vdraw;
  logic               w_in_lw;
  logic               w_in_ld;
  logic [XC_W-1:0]    w_lphase;
  logic [XC_W-1:0]    w_dphase;
  logic [XC_W-1:0]    w_xchar_n;
  logic [COLS_W-1:0]  w_xtext_n;
  logic [YC_W-1:0]    w_ychar_n;
  logic [ROWS_W-1:0]  w_ytext_n;
  logic               w_load_c;
  logic               w_load_d;
  logic               w_draw_c;

  // Next counter state and every output derived from it
  always_comb begin
    w_x_wrap  = (xpos == COORD_W'(HT - 1));
    w_y_wrap  = w_x_wrap && (ypos == COORD_W'(VT - 1));
    w_nx      = w_x_wrap ? '0 : xpos + COORD_W'(1);
    w_ny      = ypos;
    if (w_x_wrap) begin
      w_ny = w_y_wrap ? '0 : ypos + COORD_W'(1);
    end

    w_hdraw   = (w_nx >= COORD_W'(H_BACK)) && (w_nx < COORD_W'(H_VIS_END));
    w_vdraw   = (w_ny >= COORD_W'(V_BACK)) && (w_ny < COORD_W'(V_VIS_END));

    // Pixel within the cell; the pixel before the first cell reads as a cell end
    w_xchar_n = '0;
    if (w_hdraw) begin
      w_xchar_n = XC_W'(w_nx - COORD_W'(H_BACK));
    end else if (w_nx == COORD_W'(DC_START)) begin
      w_xchar_n = '1;
    end

    // Load window and its delayed copy for the glyph-row fetch
    w_in_lw   = (w_nx >= COORD_W'(LW_START)) && (w_nx < COORD_W'(LW_END));
    w_in_ld   = (w_nx >= COORD_W'(LD_START)) && (w_nx < COORD_W'(LD_END));
    w_lphase  = XC_W'(w_nx - COORD_W'(LW_START));
    w_dphase  = XC_W'(w_nx - COORD_W'(LD_START));
    w_load_c  = w_vdraw && w_in_lw && (w_lphase == '0);
    w_load_d  = w_vdraw && w_in_ld && (w_dphase == '0);
    w_draw_c  = w_vdraw && (w_nx >= COORD_W'(DC_START)) &&
                (w_nx < COORD_W'(H_VIS_END)) && (w_xchar_n == '1);

    // Text column: cell counter that restarts at the window start
    w_xtext_n = xtext;
    if (!w_in_lw || (w_nx == COORD_W'(LW_START))) begin
      w_xtext_n = '0;
    end else if (w_lphase == '0) begin
      w_xtext_n = xtext + COLS_W'(1);
    end

    // Cell row counters step once per line, restarting on the first visible line
    w_ychar_n = ychar;
    w_ytext_n = ytext;
    if (w_x_wrap) begin
      if (!w_vdraw || (w_ny == COORD_W'(V_BACK))) begin
        w_ychar_n = '0;
        w_ytext_n = '0;
      end else if (ychar == YC_W'(CHAR_H - 1)) begin
        w_ychar_n = '0;
        w_ytext_n = ytext + ROWS_W'(1);
      end else begin
        w_ychar_n = ychar + YC_W'(1);
      end
    end
  end

  // Output registers: reset matches the (0,0) state, hold while pix_en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xpos        <= '0;
      ypos        <= '0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      drawing     <= 1'b0;
      xchar       <= '0;
      ychar       <= '0;
      xtext       <= '0;
      ytext       <= '0;
      load_char   <= 1'b0;
      load_design <= 1'b0;
      draw_char   <= 1'b0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      frame_count <= '0;
    end else if (pix_en) begin
      xpos        <= w_nx;
      ypos        <= w_ny;
      hsync       <= (w_nx >= COORD_W'(H_SYNC_ST)) ? HS_ACT : ~HS_ACT;
      vsync       <= (w_ny >= COORD_W'(V_SYNC_ST)) ? VS_ACT : ~VS_ACT;
      drawing     <= w_hdraw && w_vdraw;
      xchar       <= w_xchar_n;
      ychar       <= w_ychar_n;
      xtext       <= w_xtext_n;
      ytext       <= w_ytext_n;
      load_char   <= w_load_c;
      load_design <= w_load_d;
      draw_char   <= w_draw_c;
      line_start  <= (w_nx == '0);
      frame_start <= (w_nx == '0) && (w_ny == '0);
      if (w_y_wrap) begin
        frame_count <= frame_count + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: a default-mode instance and a small fast mode
// (positive syncs, 4x5 cells) checked every cycle against an arithmetic model.
module tb_vga_timing_param;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [15:0] x;
    logic [15:0] y;
    logic        dr;
    logic [7:0]  xc;
    logic [7:0]  yc;
    logic [7:0]  xt;
    logic [7:0]  yt;
    logic        lc;
    logic        ld;
    logic        dc;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    int hb, hv, hf, hs, vb, vv, vf, vs;
    bit hp, vp;
    int cw, ch, ll, dl, cols_w, rows_w, fcnt_w;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  cfg_t c0, c1;
  int m0x, m0y, m0f, m1x, m1y, m1f;

  // default instance
  logic        rst0 = 1'b1, pe0 = 1'b0;
  logic        hsync0, vsync0, drawing0, lc0, ld0, dc0, ls0, fs0;
  logic [10:0] xpos0, ypos0;
  logic [2:0]  xchar0;
  logic [3:0]  ychar0;
  logic [6:0]  xtext0;
  logic [5:0]  ytext0, fc0;

  vga_timing_param dut0 (
    .clk(clk), .reset(rst0), .pix_en(pe0), .hsync(hsync0), .vsync(vsync0),
    .xpos(xpos0), .ypos(ypos0), .drawing(drawing0), .xchar(xchar0), .ychar(ychar0),
    .xtext(xtext0), .ytext(ytext0), .load_char(lc0), .load_design(ld0),
    .draw_char(dc0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0));

  // small mode instance: HT=30, VT=14
  logic        rst1 = 1'b1, pe1 = 1'b0;
  logic        hsync1, vsync1, drawing1, lc1, ld1, dc1, ls1, fs1;
  logic [10:0] xpos1, ypos1;
  logic [1:0]  xchar1;
  logic [2:0]  ychar1;
  logic [6:0]  xtext1;
  logic [5:0]  ytext1, fc1;

  vga_timing_param #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(9),
    .V_VISIBLE(9), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1), .VSYNC_POL(1), .CHAR_W(4), .CHAR_H(5),
    .LOAD_LEAD(7), .DESIGN_LAG(2)
  ) dut1 (
    .clk(clk), .reset(rst1), .pix_en(pe1), .hsync(hsync1), .vsync(vsync1),
    .xpos(xpos1), .ypos(ypos1), .drawing(drawing1), .xchar(xchar1), .ychar(ychar1),
    .xtext(xtext1), .ytext(ytext1), .load_char(lc1), .load_design(ld1),
    .draw_char(dc1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1));

  obs_t act0, act1;

  // Pack observed outputs for whole-state comparison
  always_comb begin
    act0 = '0;
    act0.hs = hsync0; act0.vs = vsync0; act0.x = 16'(xpos0); act0.y = 16'(ypos0);
    act0.dr = drawing0; act0.xc = 8'(xchar0); act0.yc = 8'(ychar0);
    act0.xt = 8'(xtext0); act0.yt = 8'(ytext0); act0.lc = lc0; act0.ld = ld0;
    act0.dc = dc0; act0.ls = ls0; act0.fs = fs0; act0.fc = 8'(fc0);
    act1 = '0;
    act1.hs = hsync1; act1.vs = vsync1; act1.x = 16'(xpos1); act1.y = 16'(ypos1);
    act1.dr = drawing1; act1.xc = 8'(xchar1); act1.yc = 8'(ychar1);
    act1.xt = 8'(xtext1); act1.yt = 8'(ytext1); act1.lc = lc1; act1.ld = ld1;
    act1.dc = dc1; act1.ls = ls1; act1.fs = fs1; act1.fc = 8'(fc1);
  end

  // Expected outputs for position (x,y) and frame count, straight from the timing rules
  function automatic obs_t model(input cfg_t c, input int x, input int y, input int fc);
    obs_t o;
    int ht, vt, lws, lwe, xd, xc;
    bit hd, vd, inlw;
    ht   = c.hb + c.hv + c.hf + c.hs;
    vt   = c.vb + c.vv + c.vf + c.vs;
    hd   = (x >= c.hb) && (x < c.hb + c.hv);
    vd   = (y >= c.vb) && (y < c.vb + c.vv);
    lws  = c.hb - c.ll;
    lwe  = c.hb + c.hv - c.ll;
    inlw = (x >= lws) && (x < lwe);
    xd   = x - c.dl;
    if (hd) xc = (x - c.hb) % c.cw;
    else if (x == c.hb - 1) xc = c.cw - 1;
    else xc = 0;
    o = '0;
    o.hs = (x >= ht - c.hs) ? c.hp : !c.hp;
    o.vs = (y >= vt - c.vs) ? c.vp : !c.vp;
    o.x  = 16'(x);
    o.y  = 16'(y);
    o.dr = hd && vd;
    o.xc = 8'(xc);
    o.yc = vd ? 8'((y - c.vb) % c.ch) : 8'd0;
    o.yt = vd ? 8'(((y - c.vb) / c.ch) % (1 << c.rows_w)) : 8'd0;
    o.xt = inlw ? 8'(((x - lws) / c.cw) % (1 << c.cols_w)) : 8'd0;
    o.lc = vd && inlw && ((x - lws) % c.cw == 0);
    o.ld = vd && (xd >= lws) && (xd < lwe) && ((xd - lws) % c.cw == 0);
    o.dc = vd && (x >= c.hb - 1) && (x < c.hb + c.hv) && (xc == c.cw - 1);
    o.ls = (x == 0);
    o.fs = (x == 0) && (y == 0);
    o.fc = 8'(fc % (1 << c.fcnt_w));
    return o;
  endfunction

  // Advance the reference position by one pixel
  task automatic step(input cfg_t c, inout int x, inout int y, inout int f);
    x++;
    if (x == c.hb + c.hv + c.hf + c.hs) begin
      x = 0;
      y++;
      if (y == c.vb + c.vv + c.vf + c.vs) begin
        y = 0;
        f++;
      end
    end
  endtask

  task automatic adv0(input logic en);
    @(negedge clk);
    pe0 = en;
    @(posedge clk);
    if (rst0) begin m0x = 0; m0y = 0; m0f = 0; end
    else if (en) step(c0, m0x, m0y, m0f);
    #1;
  endtask

  task automatic adv1(input logic en);
    @(negedge clk);
    pe1 = en;
    @(posedge clk);
    if (rst1) begin m1x = 0; m1y = 0; m1f = 0; end
    else if (en) step(c1, m1x, m1y, m1f);
    #1;
  endtask

  task automatic test_reset;
    rst0 = 1'b1;
    m0x = 0; m0y = 0; m0f = 0;
    for (int i = 0; i < 3; i++) begin
      adv0(1'b1);
      n_cmp++;
      if ({xpos0, ypos0, hsync0, vsync0, fs0, ls0} !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL reset_values x=%0d y=%0d hs=%b vs=%b fs=%b ls=%b, want 0 0 1 1 1 1",
                 xpos0, ypos0, hsync0, vsync0, fs0, ls0);
      end
      n_cmp++;
      if (act0 !== model(c0, m0x, m0y, m0f)) begin
        n_bad++;
        $display("FAIL reset_model got=%h want=%h", act0, model(c0, m0x, m0y, m0f));
      end
    end
    rst0 = 1'b0;
  endtask

  task automatic test_first_line;
    int hs_n, hs_first, hs_last;
    hs_n = 0; hs_first = -1; hs_last = -1;
    for (int i = 1; i <= 1039; i++) begin
      adv0(1'b1);
      n_cmp++;
      if (act0 !== model(c0, m0x, m0y, m0f)) begin
        n_bad++;
        $display("FAIL line0_model x=%0d got=%h want=%h", m0x, act0, model(c0, m0x, m0y, m0f));
      end
      if (i == 1) begin
        n_cmp++;
        if ({xpos0, ls0, fs0} !== {11'd1, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL first_enable x=%0d ls=%b fs=%b, want 1 0 0", xpos0, ls0, fs0);
        end
      end
      if (hsync0 === 1'b0) begin
        hs_n++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
    end
    n_cmp++;
    if (hs_n != 120 || hs_first != 920 || hs_last != 1039) begin
      n_bad++;
      $display("FAIL hsync_window n=%0d first=%0d last=%0d, want 120 920 1039", hs_n, hs_first, hs_last);
    end
    n_cmp++;
    if (xpos0 !== 11'd1039 || ypos0 !== 11'd0) begin
      n_bad++;
      $display("FAIL line_end x=%0d y=%0d, want 1039 0", xpos0, ypos0);
    end
    adv0(1'b1);
    n_cmp++;
    if ({xpos0, ypos0, ls0} !== {11'd0, 11'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL line_wrap x=%0d y=%0d ls=%b, want 0 1 1", xpos0, ypos0, ls0);
    end
  endtask

  task automatic test_rows_strobes;
    int s10, lc_n, lc_first, lc_last, xt_bad, ld_n, ld_first, dc_n, dc_first, dc_last;
    s10 = 0; lc_n = 0; lc_first = -1; lc_last = -1; xt_bad = 0;
    ld_n = 0; ld_first = -1; dc_n = 0; dc_first = -1; dc_last = -1;
    for (int n = 0; n < 22 * 1040; n++) begin
      adv0(1'b1);
      n_cmp++;
      if (act0 !== model(c0, m0x, m0y, m0f)) begin
        n_bad++;
        $display("FAIL blank_model x=%0d y=%0d got=%h want=%h", m0x, m0y, act0, model(c0, m0x, m0y, m0f));
      end
      if (ypos0 == 11'd10 && (lc0 || ld0 || dc0)) s10++;
    end
    n_cmp++;
    if (s10 != 0) begin
      n_bad++;
      $display("FAIL strobes_y10 count=%0d, want 0", s10);
    end
    n_cmp++;
    if (ypos0 !== 11'd23 || ychar0 !== 4'd0 || ytext0 !== 6'd0) begin
      n_bad++;
      $display("FAIL row_y23 y=%0d ychar=%0d ytext=%0d, want 23 0 0", ypos0, ychar0, ytext0);
    end
    for (int n = 0; n < 1040; n++) begin
      adv0(1'b1);
      n_cmp++;
      if (act0 !== model(c0, m0x, m0y, m0f)) begin
        n_bad++;
        $display("FAIL vis_model x=%0d y=%0d got=%h want=%h", m0x, m0y, act0, model(c0, m0x, m0y, m0f));
      end
      if (ypos0 == 11'd23) begin
        if (lc0) begin
          if (lc_first < 0) lc_first = int'(xpos0);
          lc_last = int'(xpos0);
          if (int'(xtext0) != lc_n) xt_bad++;
          lc_n++;
        end
        if (ld0) begin
          if (ld_first < 0) ld_first = int'(xpos0);
          ld_n++;
        end
        if (dc0) begin
          if (dc_first < 0) dc_first = int'(xpos0);
          dc_last = int'(xpos0);
          dc_n++;
        end
      end
    end
    n_cmp++;
    if (lc_n != 100 || lc_first != 57 || lc_last != 849 || xt_bad != 0) begin
      n_bad++;
      $display("FAIL load_char n=%0d first=%0d last=%0d xtext_bad=%0d, want 100 57 849 0",
               lc_n, lc_first, lc_last, xt_bad);
    end
    n_cmp++;
    if (ld_n != 100 || ld_first != 59) begin
      n_bad++;
      $display("FAIL load_design n=%0d first=%0d, want 100 59", ld_n, ld_first);
    end
    n_cmp++;
    if (dc_n != 101 || dc_first != 63 || dc_last != 863) begin
      n_bad++;
      $display("FAIL draw_char n=%0d first=%0d last=%0d, want 101 63 863", dc_n, dc_first, dc_last);
    end
    for (int n = 0; n < 9 * 1040; n++) begin
      adv0(1'b1);
      n_cmp++;
      if (act0 !== model(c0, m0x, m0y, m0f)) begin
        n_bad++;
        $display("FAIL rows_model x=%0d y=%0d got=%h want=%h", m0x, m0y, act0, model(c0, m0x, m0y, m0f));
      end
    end
    n_cmp++;
    if (ypos0 !== 11'd33 || ychar0 !== 4'd0 || ytext0 !== 6'd1) begin
      n_bad++;
      $display("FAIL row_y33 y=%0d ychar=%0d ytext=%0d, want 33 0 1", ypos0, ychar0, ytext0);
    end
  endtask

  task automatic test_async_reset;
    for (int n = 0; n < 500; n++) adv0(1'b1);
    n_cmp++;
    if (xpos0 !== 11'd500 || drawing0 !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset x=%0d drawing=%b, want 500 1", xpos0, drawing0);
    end
    #2;
    rst0 = 1'b1;
    m0x = 0; m0y = 0; m0f = 0;
    #1;
    n_cmp++;
    if (act0 !== model(c0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL async_reset got=%h want=%h", act0, model(c0, 0, 0, 0));
    end
    adv0(1'b1);
  endtask

  task automatic test_half_rate;
    obs_t prev;
    int lc_n, dc_n;
    logic en;
    lc_n = 0; dc_n = 0;
    rst1 = 1'b1;
    for (int i = 0; i < 3; i++) adv1(1'b1);
    rst1 = 1'b0;
    prev = act1;
    for (int i = 0; i < 180; i++) begin
      en = (i % 2 == 0);
      adv1(en);
      n_cmp++;
      if (act1 !== model(c1, m1x, m1y, m1f)) begin
        n_bad++;
        $display("FAIL half_model x=%0d y=%0d got=%h want=%h", m1x, m1y, act1, model(c1, m1x, m1y, m1f));
      end
      if (!en) begin
        n_cmp++;
        if (act1 !== prev) begin
          n_bad++;
          $display("FAIL hold got=%h want=%h", act1, prev);
        end
      end else if (ypos1 == 11'd2) begin
        if (lc1) lc_n++;
        if (dc1) dc_n++;
      end
      prev = act1;
    end
    n_cmp++;
    if (xpos1 !== 11'd0 || ypos1 !== 11'd3 || lc_n != 4 || dc_n != 5) begin
      n_bad++;
      $display("FAIL half_rate x=%0d y=%0d lc=%0d dc=%0d, want 0 3 4 5", xpos1, ypos1, lc_n, dc_n);
    end
  endtask

  task automatic test_frame_wrap;
    int wraps, guard, vs_n, hs_bad;
    bit seen_wrap;
    logic [5:0] prev_fc;
    logic en;
    wraps = 0; guard = 0; vs_n = 0; hs_bad = 0; seen_wrap = 0;
    prev_fc = fc1;
    while (wraps < 70 && guard < 40000) begin
      en = ($urandom % 8) != 0;
      adv1(en);
      guard++;
      n_cmp++;
      if (act1 !== model(c1, m1x, m1y, m1f)) begin
        n_bad++;
        $display("FAIL frame_model x=%0d y=%0d got=%h want=%h", m1x, m1y, act1, model(c1, m1x, m1y, m1f));
      end
      if (en) begin
        if (xpos1 == 11'd0 && vsync1) vs_n++;
        if (hsync1 !== (xpos1 >= 11'd27)) hs_bad++;
        if (m1x == 0 && m1y == 0) wraps++;
        if (prev_fc == 6'd63 && fc1 == 6'd0) seen_wrap = 1;
        prev_fc = fc1;
      end
    end
    n_cmp++;
    if (guard >= 40000) begin
      n_bad++;
      $display("FAIL frame_timeout wraps=%0d, want 70", wraps);
    end
    n_cmp++;
    if (fc1 !== 6'd6 || fs1 !== 1'b1 || !seen_wrap) begin
      n_bad++;
      $display("FAIL frame_count fc=%0d fs=%b wrapped=%0d, want 6 1 1", fc1, fs1, seen_wrap);
    end
    n_cmp++;
    if (vs_n != 140 || hs_bad != 0) begin
      n_bad++;
      $display("FAIL sync_pos vsync_lines=%0d hsync_bad=%0d, want 140 0", vs_n, hs_bad);
    end
  endtask

  task automatic test_reset_in_sync;
    int guard;
    guard = 0;
    while (xpos1 != 11'd28 && guard < 100) begin
      adv1(1'b1);
      guard++;
    end
    n_cmp++;
    if (hsync1 !== 1'b1 || xpos1 !== 11'd28) begin
      n_bad++;
      $display("FAIL in_sync x=%0d hs=%b, want 28 1", xpos1, hsync1);
    end
    #2;
    rst1 = 1'b1;
    m1x = 0; m1y = 0; m1f = 0;
    #1;
    n_cmp++;
    if (act1 !== model(c1, 0, 0, 0) || hsync1 !== 1'b0) begin
      n_bad++;
      $display("FAIL sync_reset got=%h want=%h", act1, model(c1, 0, 0, 0));
    end
    adv1(1'b1);
  endtask

  initial begin
    c0 = '{hb:64, hv:800, hf:56, hs:120, vb:23, vv:600, vf:37, vs:6, hp:1'b0, vp:1'b0,
           cw:8, ch:10, ll:7, dl:2, cols_w:7, rows_w:6, fcnt_w:6};
    c1 = '{hb:9, hv:16, hf:2, hs:3, vb:2, vv:9, vf:1, vs:2, hp:1'b1, vp:1'b1,
           cw:4, ch:5, ll:7, dl:2, cols_w:7, rows_w:6, fcnt_w:6};
    m0x = 0; m0y = 0; m0f = 0;
    m1x = 0; m1y = 0; m1f = 0;
    test_reset();
    test_first_line();
    test_rows_strobes();
    test_async_reset();
    test_half_rate();
    test_frame_wrap();
    test_reset_in_sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
